// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the loader state encoding, stream framing constants and the capacity check.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StDone,
        StErr
    } loader_state_e;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 8 * LEN_BYTES;

    // Image capacity in words, one bit wider than the header so 2^16 stays representable.
    function automatic logic [LEN_W:0] capacity_words(input int unsigned addr_w);
        return (LEN_W + 1)'(1) << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles consecutive bytes into a little-endian word and pulses word_valid
// in the cycle the final byte of the word is presented.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned      IdxW    = $clog2(BYTES_PER_WORD);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WORD_W-9:0] acc_q, acc_d;

    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clear) begin
            idx_d = '0;
            acc_d = '0;
        end else if (byte_valid) begin
            if (idx_q == LastIdx) begin
                idx_d = '0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                for (int unsigned k = 0; k < BYTES_PER_WORD - 1; k++) begin
                    if (idx_q == IdxW'(k)) begin
                        acc_d[8*k +: 8] = byte_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

    // The last byte bypasses the accumulator so the word is complete in its arrival cycle.
    assign word_valid = byte_valid && !clear && (idx_q == LastIdx);
    assign word       = {byte_data, acc_q};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length header, writes each assembled
// word into the instruction ROM and holds the CPU in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [LEN_W:0] Capacity = capacity_words(ADDR_W);

    loader_state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  hdr_len;
    logic [ADDR_W:0]   word_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              cpu_rst_n_q;

    logic              accept;
    logic              byte_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              last_word;
    logic              hdr_too_big;

    assign accept      = in_valid && in_ready;
    assign byte_valid  = accept && (state_q == StData);
    assign hdr_len     = {in_data, len_q[7:0]};
    assign hdr_too_big = {1'b0, hdr_len} > Capacity;
    assign last_word   = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

    imem_loader_byte_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload),
        .byte_valid (byte_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StLenLo;
                StLenLo: begin
                    if (accept) begin
                        state_d = StLenHi;
                    end
                end
                StLenHi: begin
                    if (accept) begin
                        if (hdr_len == '0) begin
                            state_d = StDone;
                        end else if (hdr_too_big) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (word_valid && last_word) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StDone;
                StErr:   state_d = StErr;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StData: in_ready = !reload;
            StDone:                   load_done = 1'b1;
            StErr:                    load_err = 1'b1;
            default:                  in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt_q <= '0;
        end else if (reload) begin
            len_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            if (accept && (state_q == StLenLo)) begin
                len_q[7:0] <= in_data;
            end
            if (accept && (state_q == StLenHi)) begin
                len_q[15:8] <= in_data;
            end
            if (word_valid) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= word_valid;
            if (word_valid) begin
                mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                mem_wdata_q <= word;
            end
        end
    end

    // Released one cycle after DONE so the final write lands before the core starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_n_q <= 1'b0;
        end else begin
            cpu_rst_n_q <= (state_q == StDone) && !reload;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expected writes and status are
// derived from the byte image itself by a small behavioural model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 32;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              reload = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0]  img[$];
    logic [39:0] obs[$];

    imem_loader #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs.push_back({mem_addr, mem_wdata});
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu"}, cpu_rst_n, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_err"}, load_err, 0);
        chk({tag, "_cnt"}, word_cnt, 0);
    endtask

    task automatic build_img(input int len, input bit hdr_only);
        img.delete();
        img.push_back(8'(len));
        img.push_back(8'(len >> 8));
        if (!hdr_only) begin
            repeat (4 * len) img.push_back(8'($urandom));
        end
    endtask

    task automatic load_fixed_img();
        img.delete();
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    // Starts and ends on a falling edge; returns just after the last byte's accepting edge.
    task automatic send_n(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int   waited;
            logic rdy;
            bit   ok;
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = img[i];
            waited   = 0;
            ok       = 1'b0;
            forever begin
                rdy = in_ready;
                @(posedge clk);
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                waited++;
                if (waited > 100) begin
                    chk("hs_timeout", in_ready, 1'b1);
                    break;
                end
            end
            if (ok) @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reload(input bit junk);
        reload   = 1'b1;
        in_valid = junk;
        in_data  = 8'hA5;
        @(negedge clk);
        reload = 1'b0;
        chk("rl_done", load_done, 0);
        chk("rl_err", load_err, 0);
        chk("rl_cnt", word_cnt, 0);
        chk("rl_cpu", cpu_rst_n, 0);
        chk("rl_ready", in_ready, 0);
        obs.delete();
    endtask

    // Reference: header gives the word count; words are little-endian groups of four bytes.
    task automatic check_img(input string tag);
        int          len;
        bit          exp_err;
        logic [39:0] exp_w[$];
        repeat (2) @(negedge clk);
        len     = int'(img[0]) + 256 * int'(img[1]);
        exp_err = len > CAP;
        if (!exp_err) begin
            for (int k = 0; k < len; k++) begin
                logic [31:0] w;
                w = 0;
                for (int b = 0; b < 4; b++) begin
                    w = w + (32'(img[2 + 4 * k + b]) << (8 * b));
                end
                exp_w.push_back({8'(k), w});
            end
        end
        chk({tag, "_nwr"}, obs.size(), exp_w.size());
        for (int i = 0; i < obs.size() && i < exp_w.size(); i++) begin
            chk({tag, "_addr"}, obs[i][39:32], exp_w[i][39:32]);
            chk({tag, "_data"}, obs[i][31:0], exp_w[i][31:0]);
        end
        chk({tag, "_done"}, load_done, !exp_err);
        chk({tag, "_err"}, load_err, exp_err);
        chk({tag, "_cnt"}, word_cnt, exp_err ? 0 : len);
        chk({tag, "_cpu"}, cpu_rst_n, !exp_err);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    initial begin
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_ready", in_ready, 0);
        @(negedge clk);
        chk("lenlo_ready", in_ready, 1);

        // Two-word image back-to-back with exact strobe/release timing.
        load_fixed_img();
        send_n(img.size(), 0);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 1);
        chk("t1_wdata", mem_wdata, 32'h0010_0093);
        chk("t1_done", load_done, 1);
        chk("t1_cpu_lo", cpu_rst_n, 0);
        @(negedge clk);
        chk("t1_cpu_hi", cpu_rst_n, 1);
        chk("t1_we_off", mem_we, 0);
        chk("t1_hold", mem_wdata, 32'h0010_0093);
        check_img("t1");
        do_reload(1'b0);

        // Zero-length header.
        build_img(0, 1'b1);
        send_n(2, 0);
        chk("z_done", load_done, 1);
        chk("z_cpu_lo", cpu_rst_n, 0);
        @(negedge clk);
        chk("z_cpu_hi", cpu_rst_n, 1);
        check_img("z");
        do_reload(1'b0);

        // Oversized header, then extra bytes that must be refused.
        build_img(CAP + 1, 1'b1);
        send_n(2, 0);
        check_img("ovf");
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            chk("ovf_extra_ready", in_ready, 0);
            chk("ovf_extra_cpu", cpu_rst_n, 0);
        end
        in_valid = 1'b0;
        chk("ovf_nwr", obs.size(), 0);

        // Junk bytes during reload/IDLE, then gappy stream.
        do_reload(1'b1);
        load_fixed_img();
        send_n(img.size(), 40);
        check_img("gap");

        // Reload after the first word, then resend.
        do_reload(1'b0);
        load_fixed_img();
        send_n(6, 0);
        do_reload(1'b0);
        send_n(img.size(), 20);
        check_img("rl");

        // Asynchronous reset mid-word.
        do_reload(1'b0);
        load_fixed_img();
        send_n(4, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        chk_reset_vals("arst_hold");
        rst_n = 1'b1;
        obs.delete();
        chk("arst_idle_ready", in_ready, 0);
        send_n(img.size(), 10);
        check_img("arst");
        do_reload(1'b0);

        // Full-capacity image.
        build_img(CAP, 1'b0);
        send_n(img.size(), 10);
        check_img("full");
        do_reload(1'b0);

        for (int it = 0; it < 8; it++) begin
            build_img($urandom_range(1, 16), 1'b0);
            send_n(img.size(), $urandom_range(0, 60));
            check_img("rnd");
            do_reload(1'b0);
        end

        build_img($urandom_range(CAP + 1, 65535), 1'b1);
        send_n(2, 30);
        check_img("rnd_ovf");
        do_reload(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the RV32I SoC. Receives a byte stream (length header, then little-endian instruction words) over a valid/ready interface, writes each assembled 32-bit word into the instruction ROM's write port, and holds the CPU core in reset until the image is complete. It is the synthesizable replacement for preloading the ROM from a file at simulation start.

## Interface
- ADDR_W, 8: word-address width; image capacity is 2^ADDR_W words.
- WORD_W, 32: instruction word width; fixed at 32, parameterized only for checking.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready
- reload  in  1  single-cycle pulse; restart loading from scratch
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  word data
- cpu_rst_n  out  1  reset to CPU core, active-low
- load_done  out  1  image loaded successfully
- load_err  out  1  header length exceeds capacity
- word_cnt  out  ADDR_W+1  words written so far

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- IDLE -> LEN_LO unconditionally next cycle; in_ready = 0 in IDLE, DONE, ERR, and in any cycle where reload = 1.
- LEN_LO: accepted byte -> len[7:0]; -> LEN_HI.
- LEN_HI: accepted byte -> len[15:8]; then
  - len == 0 -> DONE (no writes).
  - len > 2^ADDR_W -> ERR.
  - else -> DATA.
- DATA: bytes packed little-endian: byte k of a word goes to bits [8k+7:8k], k = 0..3. On the 4th byte: write issued, byte index -> 0, word_cnt += 1; if word_cnt reaches len -> DONE.
- DONE: load_done = 1, cpu_rst_n released. ERR: load_err = 1, cpu_rst_n held low.
- reload in any state: -> IDLE, clears len, byte index, word_cnt, load_done, load_err; cpu_rst_n driven low. Any byte presented that cycle is not accepted.
- Partial word pending at reload or reset is discarded; nothing is written.
- Extra bytes after DONE/ERR are not accepted (in_ready = 0).

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst_n 0, load_done 0, load_err 0, word_cnt 0, state IDLE.
- in_ready is a state decode (combinational from registered state and reload); the first byte can be accepted 1 cycle after reset release.
- Throughput: 1 byte/cycle with in_valid held high; in_valid gaps are legal, and state holds.
- mem_we is registered: high for exactly the cycle after the 4th byte of a word is accepted, with mem_addr = word index (0-based) and mem_wdata = assembled word. mem_addr and mem_wdata hold their value after the strobe.
- Last word: mem_we and the entry into DONE occur in the same cycle. load_done rises that cycle. cpu_rst_n rises 1 cycle later, so the final write lands before the core leaves reset.
- len == 0: DONE entered the cycle after the 2nd header byte. cpu_rst_n rises 1 cycle after that.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, and cpu_rst_n goes low.

## Structure
- Shared SoC package holds:
  - the state enum;
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4;
  - the capacity-check constant.
- A sub-module is natural: byte_packer (byte index counter, shift/merge into a 32-bit word, word_valid pulse). The FSM, length check, address counter and cpu_rst_n release stay in imem_loader.

## Test plan
- Stream 02 00 13 00 00 00 93 00 10 00 back-to-back:
  - mem_we at addr 0 with 0x00000013, then at addr 1 with 0x00100093;
  - load_done = 1, word_cnt = 2;
  - cpu_rst_n high 1 cycle after DONE.
- Header 00 00: no mem_we; load_done = 1; cpu_rst_n high 2 cycles after the 2nd byte.
- ADDR_W = 8, header 01 01 (len 257): ERR, load_err = 1, in_ready = 0, no writes, and cpu_rst_n stays 0.
- Same 2-word image with random in_valid gaps and bytes presented while in_ready = 0 (in IDLE): identical writes, and no byte is lost or duplicated.
- reload pulsed after 6 bytes of the 2-word image, then the full image resent: exactly two writes total after the reload, with correct data; load_done is cleared on reload and cpu_rst_n drops to 0.
- rst asserted mid-word (after byte 2 of word 1), then released and the full image resent: no write of the partial word, all outputs at reset values during reset, and the final memory contents are correct.
